icache: RTL and testbench



---
 rtl/icache_pkg.sv | 15 +
 rtl/icache_refill.sv | 112 +++++++++++
 rtl/icache.sv | 97 +++++++++
 tb/tb_icache.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared sizes and refill FSM encoding for the instruction cache.
// The optional hit/miss statistics are enabled with the ICACHE_STAT_EN macro.
package icache_pkg;

   localparam int INSTRUCTION_ADDRESS_SIZE = 32;
   localparam int INSTRUCTION_SIZE         = 32;
   localparam int ICACHE_INDEX_BITS        = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } refill_state_t;

endpackage

// File: rtl/icache_refill.sv
// Miss refill engine: issues four byte reads to the memory controller and
// assembles them little-endian into one instruction word for the line write.
module icache_refill
   import icache_pkg::*;
#(
   parameter int ADDR_W = INSTRUCTION_ADDRESS_SIZE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                miss,
   input  logic [ADDR_W-3:0]   miss_line,
   input  logic                flush,
   input  logic                mem_grant,
   input  logic [7:0]          mem_data,
   output logic                mem_read_flag,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                fill_start,
   output logic                fill_valid,
   output logic [ADDR_W-3:0]   fill_line,
   output logic [31:0]         fill_word
);

   refill_state_t     state_q, state_d;
   logic [ADDR_W-3:0] line_q;
   logic [1:0]        k_q;
   logic [1:0]        r_q;
   logic              pending_q;
   logic [2:0][7:0]   bytes_q;

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      state_d       = state_q;
      mem_read_flag = 1'b0;
      mem_addr      = '0;
      fill_start    = 1'b0;
      fill_valid    = 1'b0;
      fill_line     = line_q;
      fill_word     = {mem_data, bytes_q[2], bytes_q[1], bytes_q[0]};
      case (state_q)
         IDLE: begin
            if (miss && !flush) begin
               fill_start = 1'b1;
               state_d    = FETCH;
            end
         end
         FETCH: begin
            mem_read_flag = 1'b1;
            mem_addr      = {line_q, k_q};
            if (flush)
               state_d = IDLE;
            else if (mem_grant && k_q == 2'd3)
               state_d = DRAIN;
         end
         DRAIN: begin
            fill_valid = !flush;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         mem_read_flag = 1'b0;
         mem_addr      = '0;
         fill_start    = 1'b0;
         fill_valid    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         line_q    <= '0;
         k_q       <= 2'd0;
         r_q       <= 2'd0;
         pending_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (fill_start) begin
                  line_q    <= miss_line;
                  k_q       <= 2'd0;
                  r_q       <= 2'd0;
                  pending_q <= 1'b0;
               end
            end
            FETCH: begin
               if (flush) begin
                  k_q       <= 2'd0;
                  r_q       <= 2'd0;
                  pending_q <= 1'b0;
               end else begin
                  pending_q <= mem_grant;
                  if (mem_grant) k_q <= k_q + 2'd1;
                  if (pending_q) r_q <= r_q + 2'd1;
               end
            end
            default: begin
               k_q       <= 2'd0;
               r_q       <= 2'd0;
               pending_q <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: assembly bytes are pure datapath; the FSM decides when they are used, so no reset.
   always_ff @(posedge clk) begin
      if (state_q == FETCH && !flush && pending_q)
         bytes_q[r_q] <= mem_data;
   end

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with combinational hits.
// Define ICACHE_STAT_EN to add the hit_count / miss_count outputs.
module icache
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = ICACHE_INDEX_BITS,
   parameter int ADDR_W     = INSTRUCTION_ADDRESS_SIZE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instruction_read_flag,
   input  logic [ADDR_W-1:0] instruction_read,
   input  logic              flush,
   output logic              instruction_flag,
   output logic [31:0]       instruction,
   output logic              mem_read_flag,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_grant,
   input  logic [7:0]        mem_data
`ifdef ICACHE_STAT_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [31:0]       data_q [LINES];

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_W-1:0]      req_tag;
   logic                  hit;
   logic                  fill_start;
   logic                  fill_valid;
   logic [ADDR_W-3:0]     fill_line;
   logic [31:0]           fill_word;
   logic                  unused_addr_bits;

   assign idx              = instruction_read[INDEX_BITS+1:2];
   assign req_tag          = instruction_read[ADDR_W-1:INDEX_BITS+2];
   assign unused_addr_bits = ^instruction_read[1:0];

   assign hit              = !rst && instruction_read_flag && valid_q[idx] && (tag_q[idx] == req_tag);
   assign instruction_flag = hit;
   assign instruction      = hit ? data_q[idx] : 32'd0;

   icache_refill #(.ADDR_W(ADDR_W)) u_refill (
      .clk           (clk),
      .rst           (rst),
      .miss          (instruction_read_flag && !hit),
      .miss_line     (instruction_read[ADDR_W-1:2]),
      .flush         (flush),
      .mem_grant     (mem_grant),
      .mem_data      (mem_data),
      .mem_read_flag (mem_read_flag),
      .mem_addr      (mem_addr),
      .fill_start    (fill_start),
      .fill_valid    (fill_valid),
      .fill_line     (fill_line),
      .fill_word     (fill_word)
   );

   always_ff @(posedge clk) begin
      if (rst)
         valid_q <= '0;
      else if (fill_valid)
         valid_q[fill_line[INDEX_BITS-1:0]] <= 1'b1;
   end

   // Tag/data are qualified by valid_q, so only the valid bits need clearing.
   always_ff @(posedge clk) begin
      if (fill_valid) begin
         tag_q[fill_line[INDEX_BITS-1:0]]  <= fill_line[ADDR_W-3:INDEX_BITS];
         data_q[fill_line[INDEX_BITS-1:0]] <= fill_word;
      end
   end

`ifdef ICACHE_STAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= 32'd0;
         miss_count <= 32'd0;
      end else begin
         hit_count  <= hit_count + {31'd0, hit};
         miss_count <= miss_count + {31'd0, fill_start};
      end
   end
`else
   logic unused_fill_start;
   assign unused_fill_start = fill_start;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios then randomized traffic,
// compared cycle by cycle against a line-level cache model.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst;
   logic        instruction_read_flag;
   logic [31:0] instruction_read;
   logic        flush;
   logic        instruction_flag;
   logic [31:0] instruction;
   logic        mem_read_flag;
   logic [31:0] mem_addr;
   logic        mem_grant;
   logic [7:0]  mem_data;
`ifdef ICACHE_STAT_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   always #5 clk = ~clk;

   icache dut (
      .clk                   (clk),
      .rst                   (rst),
      .instruction_read_flag (instruction_read_flag),
      .instruction_read      (instruction_read),
      .flush                 (flush),
      .instruction_flag      (instruction_flag),
      .instruction           (instruction),
      .mem_read_flag         (mem_read_flag),
      .mem_addr              (mem_addr),
      .mem_grant             (mem_grant),
      .mem_data              (mem_data)
`ifdef ICACHE_STAT_EN
      ,
      .hit_count             (hit_count),
      .miss_count            (miss_count)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: which memory line each index holds, plus refill progress
   bit          m_valid [128];
   logic [29:0] m_line  [128];
   bit          busy;
   int          ngr;
   logic [29:0] r_line;
   int unsigned m_hits;
   int unsigned m_misses;
   logic        obs_flag;

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [31:0] w;
      w = 32'h00000513;
      if (a[31:2] == 30'h400) return w[a[1:0]*8 +: 8];
      return (a[7:0] * 8'h9d) ^ a[15:8] ^ 8'h5a;
   endfunction

   function automatic logic [31:0] mem_word(input logic [29:0] line);
      return {mem_byte({line, 2'd3}), mem_byte({line, 2'd2}),
              mem_byte({line, 2'd1}), mem_byte({line, 2'd0})};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rd, input logic [31:0] addr, input logic fl,
                       input logic gr, input logic rs);
      logic [6:0] idx;
      logic       hit_e;
      logic       fetch_e;
      logic [7:0] nxt;
      rst                   = rs;
      instruction_read_flag = rd;
      instruction_read      = addr;
      flush                 = fl;
      mem_grant             = gr;
      #1;
      idx     = addr[8:2];
      hit_e   = !rs && rd && m_valid[idx] && (m_line[idx] == addr[31:2]);
      fetch_e = !rs && busy && (ngr < 4);
      check("flag", {31'd0, instruction_flag}, {31'd0, hit_e});
      check("instr", instruction, hit_e ? mem_word(addr[31:2]) : 32'd0);
      check("mem_rd", {31'd0, mem_read_flag}, {31'd0, fetch_e});
      check("mem_addr", mem_addr, fetch_e ? ({r_line, 2'b00} + 32'(ngr)) : 32'd0);
`ifdef ICACHE_STAT_EN
      check("hit_count", hit_count, m_hits);
      check("miss_count", miss_count, m_misses);
`endif
      obs_flag = instruction_flag;
      nxt = (mem_read_flag && gr) ? mem_byte(mem_addr) : 8'($urandom);
      if (rs) begin
         for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
         busy     = 1'b0;
         m_hits   = 0;
         m_misses = 0;
      end else begin
         if (hit_e) m_hits++;
         if (!busy) begin
            if (rd && !hit_e && !fl) begin
               busy   = 1'b1;
               ngr    = 0;
               r_line = addr[31:2];
               m_misses++;
            end
         end else if (ngr < 4) begin
            if (fl) busy = 1'b0;
            else if (gr) ngr++;
         end else begin
            if (!fl) begin
               m_valid[r_line[6:0]] = 1'b1;
               m_line[r_line[6:0]]  = r_line;
            end
            busy = 1'b0;
         end
      end
      @(posedge clk);
      #1 mem_data = nxt;
      @(negedge clk);
   endtask

   // Hold a request until it hits; grant is withheld in cycles st_lo..st_hi
   task automatic run_fill(input logic [31:0] addr, input int st_lo, input int st_hi,
                           output int lat);
      lat = -1;
      for (int c = 0; c < 30; c++) begin
         step(1'b1, addr, 1'b0, !(c >= st_lo && c <= st_hi), 1'b0);
         if (obs_flag) begin
            lat = c;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      logic [31:0] a;
      rst = 1'b1;
      instruction_read_flag = 1'b0;
      instruction_read = 32'd0;
      flush = 1'b0;
      mem_grant = 1'b0;
      mem_data = 8'd0;
      busy = 1'b0;
      ngr = 0;
      r_line = '0;
      m_hits = 0;
      m_misses = 0;
      for (int i = 0; i < 128; i++) begin
         m_valid[i] = 1'b0;
         m_line[i]  = '0;
      end
      @(negedge clk);

      step(1'b1, 32'h1000, 1'b0, 1'b1, 1'b1);
      step(1'b1, 32'h1000, 1'b0, 1'b1, 1'b1);

      // Cold miss, grant always high
      run_fill(32'h1000, 99, 99, lat);
      check("lat_cold", lat, 6);
      check("word_1000", instruction, 32'h00000513);
      // Repeat request hits immediately
      run_fill(32'h1000, 99, 99, lat);
      check("lat_rehit", lat, 0);

      // Grant withheld two cycles on byte 1
      run_fill(32'h1004, 2, 3, lat);
      check("lat_stall", lat, 8);

      // Flush mid-refill redirects to a new PC
      step(1'b1, 32'h2000, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h2000, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h2000, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h3000, 1'b1, 1'b1, 1'b0);
      run_fill(32'h3000, 99, 99, lat);
      check("lat_newpc", lat, 6);
      run_fill(32'h2000, 99, 99, lat);
      check("lat_flushed", lat, 6);

      // Index aliasing
      run_fill(32'h1200, 99, 99, lat);
      check("lat_alias", lat, 6);
      run_fill(32'h1000, 99, 99, lat);
      check("lat_evicted", lat, 6);

      // Reset mid-refill, then reset after a completed fill
      step(1'b1, 32'h1200, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h1200, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h1200, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h1200, 1'b0, 1'b1, 1'b1);
      run_fill(32'h1200, 99, 99, lat);
      check("lat_after_rst", lat, 6);
      step(1'b1, 32'h1200, 1'b0, 1'b1, 1'b1);
`ifdef ICACHE_STAT_EN
      check("hits_rst", hit_count, 32'd0);
      check("miss_rst", miss_count, 32'd0);
`endif
      run_fill(32'h1200, 99, 99, lat);
      check("lat_refill_rst", lat, 6);

      // Randomized traffic over a small, aliasing address pool
      for (int n = 0; n < 800; n++) begin
         a = 32'h1000 + (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(0, 1)) << 9);
         step($urandom_range(0, 7) != 0, a, $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
